// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side and data-bus signals of the MEM-stage access sequencer.
// The slave modport is the sequencer; master is the pipeline/bus environment.
interface mem_access_ctrl_if;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_type;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        flush;
    logic        stall;
    logic        done;
    logic        exc_adel;
    logic        exc_ades;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic [31:0] ld_rdata;
    logic [1:0]  ext_a;
    logic [2:0]  ext_op;

    modport slave (
        input  req_valid, req_we, req_type, req_sign, req_addr, req_wdata, flush,
        input  bus_ack, bus_rdata,
        output stall, done, exc_adel, exc_ades,
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output ld_rdata, ext_a, ext_op
    );

    modport master (
        output req_valid, req_we, req_type, req_sign, req_addr, req_wdata, flush,
        output bus_ack, bus_rdata,
        input  stall, done, exc_adel, exc_ades,
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  ld_rdata, ext_a, ext_op
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: alignment/range faults, req/ack bus access, load capture.
// Define MEM_TIMEOUT_EN to abort a bus access after TIMEOUT_CYCLES unacknowledged REQ cycles.
module mem_access_ctrl #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000
`ifdef MEM_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
    input logic              clk,
    input logic              reset,
    mem_access_ctrl_if.slave mif
);

    typedef enum logic [1:0] {IDLE, REQ, DONE, TOUT} state_e;

    state_e      state_q;
    logic        bus_req_q, bus_we_q, done_q;
    logic [31:0] bus_addr_q, bus_wdata_q, ld_rdata_q;
    logic [3:0]  bus_be_q;
    logic [1:0]  ext_a_q;
    logic [2:0]  ext_op_q;

    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [2:0]  ext_op_d;
    logic        misalign, fault, issue, accept;
    logic        tout_adel, tout_ades;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        be_d     = 4'b0000;
        wdata_d  = mif.req_wdata;
        ext_op_d = 3'd0;
        misalign = 1'b0;
        case (mif.req_type)
            2'd0: begin
                be_d     = 4'b1111;
                misalign = (mif.req_addr[1:0] != 2'b00);
            end
            2'd1: begin
                be_d     = mif.req_addr[1] ? 4'b1100 : 4'b0011;
                misalign = mif.req_addr[0];
                wdata_d  = {2{mif.req_wdata[15:0]}};
                ext_op_d = mif.req_we ? 3'd0 : (mif.req_sign ? 3'd4 : 3'd3);
            end
            2'd2: begin
                be_d     = 4'b0001 << mif.req_addr[1:0];
                wdata_d  = {4{mif.req_wdata[7:0]}};
                ext_op_d = mif.req_we ? 3'd0 : (mif.req_sign ? 3'd2 : 3'd1);
            end
            default: misalign = 1'b1;
        endcase
    end

    // flush only matters while IDLE; once on the bus the access always completes.
    assign fault  = misalign || (mif.req_addr >= ADDR_LIMIT);
    assign issue  = !reset && (state_q == IDLE) && mif.req_valid && !mif.flush;
    assign accept = issue && !fault;

`ifdef MEM_TIMEOUT_EN
    logic [31:0] wait_q;
    assign tout_adel = (state_q == TOUT) && !bus_we_q;
    assign tout_ades = (state_q == TOUT) &&  bus_we_q;
`else
    assign tout_adel = 1'b0;
    assign tout_ades = 1'b0;
`endif

    assign mif.exc_adel  = (issue && fault && !mif.req_we) || tout_adel;
    assign mif.exc_ades  = (issue && fault &&  mif.req_we) || tout_ades;
    assign mif.stall     = accept || (state_q == REQ);
    assign mif.done      = done_q;
    assign mif.bus_req   = bus_req_q;
    assign mif.bus_we    = bus_we_q;
    assign mif.bus_addr  = bus_addr_q;
    assign mif.bus_be    = bus_be_q;
    assign mif.bus_wdata = bus_wdata_q;
    assign mif.ld_rdata  = ld_rdata_q;
    assign mif.ext_a     = ext_a_q;
    assign mif.ext_op    = ext_op_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_be_q    <= 4'd0;
            bus_wdata_q <= 32'd0;
            ld_rdata_q  <= 32'd0;
            ext_a_q     <= 2'd0;
            ext_op_q    <= 3'd0;
            done_q      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wait_q      <= 32'd0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q     <= REQ;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= mif.req_we;
                        bus_addr_q  <= {mif.req_addr[31:2], 2'b00};
                        bus_be_q    <= be_d;
                        bus_wdata_q <= wdata_d;
                        ext_a_q     <= mif.req_addr[1:0];
                        ext_op_q    <= ext_op_d;
`ifdef MEM_TIMEOUT_EN
                        wait_q      <= 32'd0;
`endif
                    end
                end
                REQ: begin
                    if (mif.bus_ack) begin
                        state_q   <= DONE;
                        bus_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        if (!bus_we_q) ld_rdata_q <= mif.bus_rdata;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (wait_q == TIMEOUT_CYCLES - 1) begin
                        state_q   <= TOUT;
                        bus_req_q <= 1'b0;
                    end else begin
                        wait_q <= wait_q + 32'd1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: spec-level model plus per-cycle compare process.
// With MEM_TIMEOUT_EN defined the DUT runs with TIMEOUT_CYCLES = 4 and a timeout case is added.
module tb_mem_access_ctrl;

    localparam logic [31:0] LIMIT = 32'h0000_3000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_access_ctrl_if mif();

    mem_access_ctrl #(
        .ADDR_LIMIT(LIMIT)
`ifdef MEM_TIMEOUT_EN
        , .TIMEOUT_CYCLES(4)
`endif
    ) dut (
        .clk  (clk),
        .reset(reset),
        .mif  (mif)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // Access rules expressed arithmetically: size in bytes, lane mask, replication by multiply.
    function automatic void model(input logic we, input logic [1:0] typ, input logic sgn,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  output logic fault, output logic [3:0] be,
                                  output logic [31:0] wrep, output logic [2:0] op);
        int size;
        size  = (typ == 2'd0) ? 4 : (typ == 2'd1) ? 2 : 1;
        fault = (typ == 2'd3) || ((addr % size) != 0) || (addr >= LIMIT);
        be    = 4'(((1 << size) - 1) << (addr % 4));
        if (size == 4)      wrep = wd;
        else if (size == 2) wrep = (wd & 32'h0000_FFFF) * 32'h0001_0001;
        else                wrep = (wd & 32'h0000_00FF) * 32'h0101_0101;
        op = (we || size == 4) ? 3'd0 : 3'((size == 1 ? 1 : 3) + (sgn ? 1 : 0));
    endfunction

    logic        chk_en;
    logic        exp_stall, exp_done, exp_adel, exp_ades, exp_bus_req, exp_we;
    logic [31:0] exp_addr, exp_wdata, exp_ld;
    logic [3:0]  exp_be;
    logic [1:0]  exp_ext_a;
    logic [2:0]  exp_ext_op;

    always @(negedge clk) begin
        if (chk_en) begin
            check("stall",    mif.stall,    exp_stall);
            check("done",     mif.done,     exp_done);
            check("exc_adel", mif.exc_adel, exp_adel);
            check("exc_ades", mif.exc_ades, exp_ades);
            check("bus_req",  mif.bus_req,  exp_bus_req);
            check("ld_rdata", mif.ld_rdata, exp_ld);
            if (exp_bus_req) begin
                check("bus_we",   mif.bus_we,   exp_we);
                check("bus_addr", mif.bus_addr, exp_addr);
                check("bus_be",   mif.bus_be,   exp_be);
                if (exp_we) check("bus_wdata", mif.bus_wdata, exp_wdata);
            end
            if (exp_done) begin
                check("ext_a",  mif.ext_a,  exp_ext_a);
                check("ext_op", mif.ext_op, exp_ext_op);
            end
        end
    end

    task automatic set_idle();
        mif.req_valid = 1'b0; mif.req_we = 1'b0; mif.req_type = 2'd0; mif.req_sign = 1'b0;
        mif.req_addr = 32'd0; mif.req_wdata = 32'd0; mif.flush = 1'b0;
        mif.bus_ack = 1'b0; mif.bus_rdata = 32'd0;
        exp_stall = 1'b0; exp_done = 1'b0; exp_adel = 1'b0; exp_ades = 1'b0; exp_bus_req = 1'b0;
    endtask

    // One instruction held in MEM until done (or for one cycle if it faults).
    task automatic run_txn(input logic we, input logic [1:0] typ, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wd, input int waits,
                           input logic [31:0] rdata, input logic flush_req,
                           output logic [3:0] obs_be, output logic [31:0] obs_wdata,
                           output logic [31:0] obs_addr, output int stall_cycles,
                           output int done_cycle, output logic obs_exc);
        logic fault; logic [3:0] be; logic [31:0] wrep; logic [2:0] op;
        model(we, typ, sgn, addr, wd, fault, be, wrep, op);
        stall_cycles = 0; done_cycle = -1; obs_exc = 1'b0;
        obs_be = 4'd0; obs_wdata = 32'd0; obs_addr = 32'd0;
        @(posedge clk); #1;
        mif.req_valid = 1'b1; mif.req_we = we; mif.req_type = typ; mif.req_sign = sgn;
        mif.req_addr = addr; mif.req_wdata = wd; mif.flush = 1'b0;
        mif.bus_ack = 1'b0; mif.bus_rdata = rdata;
        exp_stall = !fault; exp_adel = fault && !we; exp_ades = fault && we;
        exp_bus_req = 1'b0; exp_done = 1'b0;
        #1;
        stall_cycles += int'(mif.stall);
        obs_exc = mif.exc_adel | mif.exc_ades;
        if (!fault) begin
            for (int k = 0; k <= waits; k++) begin
                @(posedge clk); #1;
                mif.flush = flush_req;
                mif.bus_ack = (k == waits);
                exp_stall = 1'b1; exp_adel = 1'b0; exp_ades = 1'b0; exp_bus_req = 1'b1;
                exp_we = we; exp_addr = addr & ~32'h3; exp_be = be; exp_wdata = wrep;
                #1;
                stall_cycles += int'(mif.stall);
                obs_be = mif.bus_be; obs_wdata = mif.bus_wdata; obs_addr = mif.bus_addr;
            end
            @(posedge clk); #1;
            mif.bus_ack = 1'b0;
            exp_stall = 1'b0; exp_bus_req = 1'b0; exp_done = 1'b1;
            if (!we) exp_ld = rdata;
            exp_ext_a = addr[1:0]; exp_ext_op = op;
            #1;
            stall_cycles += int'(mif.stall);
            if (mif.done) done_cycle = waits + 2;
        end
        @(posedge clk); #1;
        set_idle();
    endtask

    logic [3:0]  o_be;
    logic [31:0] o_wd, o_ad;
    int          o_sc, o_dc;
    logic        o_ex;
    logic        m_fault;
    logic [3:0]  m_be;
    logic [31:0] m_wrep;
    logic [2:0]  m_op;

    initial begin
        chk_en = 1'b0; exp_ld = 32'd0; exp_we = 1'b0; exp_addr = 32'd0; exp_wdata = 32'd0;
        exp_be = 4'd0; exp_ext_a = 2'd0; exp_ext_op = 3'd0;
        set_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_bus_req", mif.bus_req, 32'd0);
        check("rst_done",    mif.done,    32'd0);
        check("rst_stall",   mif.stall,   32'd0);
        check("rst_bus_be",  mif.bus_be,  32'd0);
        check("rst_addr",    mif.bus_addr, 32'd0);
        check("rst_ld",      mif.ld_rdata, 32'd0);
        check("rst_ext_op",  mif.ext_op,  32'd0);
        reset = 1'b0;
        chk_en = 1'b1;

        // Pin the model itself against hand-derived values.
        model(1'b0, 2'd2, 1'b0, 32'h0000_1003, 32'd0, m_fault, m_be, m_wrep, m_op);
        check("model_lbu_be", m_be, 32'b1000);
        check("model_lbu_op", m_op, 32'd1);
        model(1'b1, 2'd1, 1'b0, 32'h0000_0102, 32'h1234_ABCD, m_fault, m_be, m_wrep, m_op);
        check("model_sh_wd", m_wrep, 32'hABCD_ABCD);
        model(1'b1, 2'd0, 1'b0, 32'h0000_3000, 32'd0, m_fault, m_be, m_wrep, m_op);
        check("model_sw_limit", m_fault, 32'd1);

        // lbu 0x1003, zero-wait
        run_txn(1'b0, 2'd2, 1'b0, 32'h0000_1003, 32'd0, 0, 32'hAABB_CCDD, 1'b0,
                o_be, o_wd, o_ad, o_sc, o_dc, o_ex);
        check("lbu_be", o_be, 32'b1000);
        check("lbu_addr", o_ad, 32'h0000_1000);
        check("lbu_done_cyc", o_dc, 32'd2);
        check("lbu_ld", mif.ld_rdata, 32'hAABB_CCDD);
        check("lbu_ext_a", mif.ext_a, 32'd3);
        check("lbu_ext_op", mif.ext_op, 32'd1);

        // sh 0x0102, three wait cycles
        run_txn(1'b1, 2'd1, 1'b0, 32'h0000_0102, 32'h1234_ABCD, 3, 32'hFFFF_0000, 1'b0,
                o_be, o_wd, o_ad, o_sc, o_dc, o_ex);
        check("sh_be", o_be, 32'b1100);
        check("sh_wdata", o_wd, 32'hABCD_ABCD);
        check("sh_stall_cyc", o_sc, 32'd5);
        check("sh_done_cyc", o_dc, 32'd5);
        check("sh_ld_kept", mif.ld_rdata, 32'hAABB_CCDD);

        // misaligned lw, out-of-range sw
        run_txn(1'b0, 2'd0, 1'b0, 32'h0000_0006, 32'd0, 0, 32'd0, 1'b0,
                o_be, o_wd, o_ad, o_sc, o_dc, o_ex);
        check("lw_mis_exc", o_ex, 32'd1);
        check("lw_mis_stall", o_sc, 32'd0);
        run_txn(1'b1, 2'd0, 1'b0, 32'h0000_3000, 32'h1111_2222, 0, 32'd0, 1'b0,
                o_be, o_wd, o_ad, o_sc, o_dc, o_ex);
        check("sw_lim_exc", o_ex, 32'd1);

        // sw to the last legal word, one wait
        run_txn(1'b1, 2'd0, 1'b0, 32'h0000_2FFC, 32'hDEAD_BEEF, 1, 32'h0BAD_0BAD, 1'b0,
                o_be, o_wd, o_ad, o_sc, o_dc, o_ex);
        check("sw_edge_addr", o_ad, 32'h0000_2FFC);
        check("sw_edge_wd", o_wd, 32'hDEAD_BEEF);
        check("sw_edge_done", o_dc, 32'd3);
        check("sw_ld_kept", mif.ld_rdata, 32'hAABB_CCDD);

        // signed lh at upper half
        run_txn(1'b0, 2'd1, 1'b1, 32'h0000_0022, 32'd0, 0, 32'h8001_0000, 1'b0,
                o_be, o_wd, o_ad, o_sc, o_dc, o_ex);
        check("lh_be", o_be, 32'b1100);
        check("lh_ext_op", mif.ext_op, 32'd4);
        check("lh_ext_a", mif.ext_a, 32'd2);

        // sb presented with flush in IDLE: nothing happens
        @(posedge clk); #1;
        mif.req_valid = 1'b1; mif.req_we = 1'b1; mif.req_type = 2'd2;
        mif.req_addr = 32'h0000_0041; mif.req_wdata = 32'h55; mif.flush = 1'b1;
        #1;
        check("flush_stall", mif.stall, 32'd0);
        check("flush_exc", mif.exc_ades, 32'd0);
        @(posedge clk); #2;
        check("flush_no_req", mif.bus_req, 32'd0);
        set_idle();

        // sb with flush raised during REQ completes normally
        run_txn(1'b1, 2'd2, 1'b0, 32'h0000_0041, 32'h0000_0055, 2, 32'd0, 1'b1,
                o_be, o_wd, o_ad, o_sc, o_dc, o_ex);
        check("sb_fl_be", o_be, 32'b0010);
        check("sb_fl_wd", o_wd, 32'h5555_5555);
        check("sb_fl_done", o_dc, 32'd4);

        // illegal type load, misaligned half store
        run_txn(1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'd0, 0, 32'd0, 1'b0,
                o_be, o_wd, o_ad, o_sc, o_dc, o_ex);
        check("ltype3_exc", o_ex, 32'd1);
        run_txn(1'b1, 2'd1, 1'b0, 32'h0000_0011, 32'd0, 0, 32'd0, 1'b0,
                o_be, o_wd, o_ad, o_sc, o_dc, o_ex);
        check("sh_mis_exc", o_ex, 32'd1);

        // signed lb lane 2
        run_txn(1'b0, 2'd2, 1'b1, 32'h0000_0002, 32'd0, 0, 32'h0080_0000, 1'b0,
                o_be, o_wd, o_ad, o_sc, o_dc, o_ex);
        check("lb_be", o_be, 32'b0100);
        check("lb_ext_op", mif.ext_op, 32'd2);
        check("lb_ld", mif.ld_rdata, 32'h0080_0000);

        // reset in REQ, late ack must be dropped
        chk_en = 1'b0;
        @(posedge clk); #1;
        mif.req_valid = 1'b1; mif.req_type = 2'd0; mif.req_addr = 32'h0000_0100;
        @(posedge clk); #2;
        check("rst_req_busreq", mif.bus_req, 32'd1);
        reset = 1'b1; mif.req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; mif.bus_ack = 1'b1; mif.bus_rdata = 32'h1234_5678;
        #1;
        check("rreq_bus_req", mif.bus_req, 32'd0);
        check("rreq_stall", mif.stall, 32'd0);
        check("rreq_be", mif.bus_be, 32'd0);
        check("rreq_ld", mif.ld_rdata, 32'd0);
        @(posedge clk); #1;
        mif.bus_ack = 1'b0;
        #1;
        check("rreq_ack_done", mif.done, 32'd0);
        check("rreq_ack_ld", mif.ld_rdata, 32'd0);
        check("rreq_ack_req", mif.bus_req, 32'd0);
        exp_ld = 32'd0;
        set_idle();
        chk_en = 1'b1;

`ifdef MEM_TIMEOUT_EN
        // lh 0x0010 never acknowledged
        chk_en = 1'b0;
        @(posedge clk); #1;
        mif.req_valid = 1'b1; mif.req_type = 2'd1; mif.req_addr = 32'h0000_0010;
        #1;
        check("to_accept_stall", mif.stall, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            check("to_req", mif.bus_req, 32'd1);
            check("to_req_exc", mif.exc_adel, 32'd0);
        end
        @(posedge clk); #2;
        check("to_exc", mif.exc_adel, 32'd1);
        check("to_req_drop", mif.bus_req, 32'd0);
        check("to_done", mif.done, 32'd0);
        check("to_stall", mif.stall, 32'd0);
        @(posedge clk); #1;
        set_idle();
        #1;
        check("to_exc_pulse", mif.exc_adel, 32'd0);
        chk_en = 1'b1;
`endif

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
